// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t     : loader FSM states (IDLE=0, COLLECT=1, WRITE=2, DONE=3)
//   WORD_BYTES  : bytes per instruction word
//   lane_of()   : maps the running byte index to the byte lane it fills
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

  // Big-endian packing puts the first byte in the top lane.
  function automatic logic [1:0] lane_of(input logic [1:0] idx, input logic big_endian);
    return big_endian ? (2'd3 - idx) : idx;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four bytes into one 32-bit word.
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   clr      in   discard the partially assembled word
//   byte_en  in   write byte_in into the lane selected by idx
//   byte_in  in   incoming byte
//   idx      in   ordinal of this byte within the word (0 = first)
//   word     out  assembled word
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  input  logic [1:0]  idx,
  output logic [31:0] word
);

  logic [1:0] lane;

  assign lane = lane_of(idx, BIG_ENDIAN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (byte_en) begin
      word[{lane, 3'b000} +: 8] <= byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory.
// Bytes arrive over a valid/ready handshake, are packed into 32-bit words and
// written to consecutive word addresses while the CPU fetch path is held.
//   clk, reset       clock / asynchronous active-low reset
//   start, abort     begin a load (IDLE only) / cancel a running load
//   base_addr        first write address (low two bits ignored)
//   word_count       number of words to load (0 = immediate done)
//   in_valid/in_byte/in_ready   byte stream handshake
//   IM_cs/IM_wr/IM_addr/IM_D_in instruction memory write port
//   cpu_hold         high whenever the loader is busy
//   done             one-cycle completion pulse
//   aborted          sticky abort flag, cleared by the next accepted start
//   words_written    words committed in the current/last load
//   checksum         XOR of all words committed in the current/last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              IM_cs,
  output logic              IM_wr,
  output logic [ADDR_W-1:0] IM_addr,
  output logic [31:0]       IM_D_in,
  output logic              cpu_hold,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  words_written,
  output logic [31:0]       checksum
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_reg;
  logic [CNT_W-1:0]   len_reg;
  logic [1:0]         byte_idx;
  logic [ADDR_W-1:0]  last_addr;
  logic [31:0]        last_data;
  logic [31:0]        pk_word;
  logic [CNT_W-1:0]   ww_inc;

  logic start_acc;
  logic accept;
  logic commit;
  logic abort_busy;

  assign start_acc  = (state_q == ST_IDLE) && start && !abort;
  assign accept     = (state_q == ST_COLLECT) && in_valid;
  assign commit     = (state_q == ST_WRITE);
  assign abort_busy = abort && (state_q != ST_IDLE);
  assign ww_inc     = words_written + 1'b1;

  byte_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_acc || abort_busy || commit),
    .byte_en (accept),
    .byte_in (in_byte),
    .idx     (byte_idx),
    .word    (pk_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = (word_count == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept && (byte_idx == 2'(WORD_BYTES - 1))) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ww_inc == len_reg) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A write cycle that coincides with abort still commits: its strobe is
  // already on the memory bus, so the bookkeeping must reflect it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg      <= '0;
      len_reg       <= '0;
      byte_idx      <= '0;
      words_written <= '0;
      checksum      <= '0;
      aborted       <= 1'b0;
      last_addr     <= '0;
      last_data     <= '0;
    end else begin
      if (start_acc) begin
        addr_reg      <= {base_addr[ADDR_W-1:2], 2'b00};
        len_reg       <= word_count;
        byte_idx      <= '0;
        words_written <= '0;
        checksum      <= '0;
        aborted       <= 1'b0;
      end
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
      end
      if (commit) begin
        addr_reg      <= addr_reg + ADDR_W'(WORD_BYTES);
        words_written <= ww_inc;
        checksum      <= checksum ^ pk_word;
        byte_idx      <= '0;
        last_addr     <= addr_reg;
        last_data     <= pk_word;
      end
      if (abort_busy) begin
        aborted  <= 1'b1;
        byte_idx <= '0;
      end
    end
  end

  // Address/data show the live values during the write strobe and keep the
  // last written values otherwise.
  assign in_ready = (state_q == ST_COLLECT);
  assign IM_cs    = commit;
  assign IM_wr    = commit;
  assign IM_addr  = commit ? addr_reg : last_addr;
  assign IM_D_in  = commit ? pk_word : last_data;
  assign cpu_hold = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE) && !abort;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        IM_cs;
  logic        IM_wr;
  logic [31:0] IM_addr;
  logic [31:0] IM_D_in;
  logic        cpu_hold;
  logic        done;
  logic        aborted;
  logic [15:0] words_written;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W     (32),
    .CNT_W      (16),
    .BIG_ENDIAN (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .in_valid      (in_valid),
    .in_byte       (in_byte),
    .in_ready      (in_ready),
    .IM_cs         (IM_cs),
    .IM_wr         (IM_wr),
    .IM_addr       (IM_addr),
    .IM_D_in       (IM_D_in),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .aborted       (aborted),
    .words_written (words_written),
    .checksum      (checksum)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  stim[$];
  int          done_cnt = 0;
  int          hold_cnt = 0;

  // Observation only: record every write strobe and count done/hold cycles.
  always @(negedge clk) begin
    if (IM_wr === 1'b1 && IM_cs === 1'b1) begin
      wr_addr_q.push_back(IM_addr);
      wr_data_q.push_back(IM_D_in);
    end
    if (done === 1'b1) done_cnt++;
    if (cpu_hold === 1'b1) hold_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gapmode < 0: random 0..3 idle cycles before each offer; else fixed gap.
  task automatic feed(input int nbytes, input int gapmode);
    int   idx = 0;
    int   cyc = 0;
    logic r;
    while (idx < nbytes && cyc < 2000) begin
      int g;
      g = (gapmode < 0) ? int'($urandom_range(0, 3)) : gapmode;
      in_valid = 1'b0;
      repeat (g) begin
        step();
        cyc++;
      end
      in_valid = 1'b1;
      in_byte  = stim[idx];
      @(negedge clk);
      r = in_ready;
      step();
      cyc++;
      if (r === 1'b1) idx++;
    end
    in_valid = 1'b0;
    if (idx < nbytes) chk("feed_timeout", 64'(idx), 64'(nbytes));
  endtask

  task automatic wait_idle();
    int c = 0;
    while (cpu_hold === 1'b1 && c < 200) begin
      step();
      c++;
    end
    chk("idle_reached", {63'd0, cpu_hold}, 64'd0);
  endtask

  // Reference: word i is bytes 4i..4i+3 with the first byte most significant;
  // word i lands at the aligned base plus 4*i, wrapping at 2^32.
  function automatic logic [31:0] exp_word(input int i);
    return {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    logic [31:0] a;
    a = (base / 32'd4) * 32'd4;
    return a + 32'(4 * i);
  endfunction

  task automatic check_model(input string tag, input logic [31:0] base, input int cnt);
    logic [31:0] x = 32'd0;
    chk($sformatf("%s_nwrites", tag), 64'(wr_addr_q.size()), 64'(cnt));
    for (int i = 0; i < cnt; i++) begin
      x ^= exp_word(i);
      if (i < wr_addr_q.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_q[i]), 64'(exp_addr(base, i)));
        chk($sformatf("%s_data%0d", tag, i), 64'(wr_data_q[i]), 64'(exp_word(i)));
      end
    end
    chk($sformatf("%s_done_pulses", tag), 64'(done_cnt), 64'd1);
    chk($sformatf("%s_words_written", tag), 64'(words_written), 64'(cnt));
    chk($sformatf("%s_checksum", tag), 64'(checksum), 64'(x));
    chk($sformatf("%s_aborted", tag), {63'd0, aborted}, 64'd0);
    if (cnt > 0) chk($sformatf("%s_addr_hold", tag), 64'(IM_addr), 64'(exp_addr(base, cnt - 1)));
  endtask

  task automatic run_load(input string tag, input logic [31:0] base, input int cnt,
                          input int gapmode);
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt   = 0;
    hold_cnt   = 0;
    base_addr  = base;
    word_count = 16'(cnt);
    start      = 1'b1;
    step();
    start      = 1'b0;
    feed(4 * cnt, gapmode);
    wait_idle();
    check_model(tag, base, cnt);
  endtask

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  initial begin
    start      = 1'b0;
    abort      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_valid   = 1'b0;
    in_byte    = '0;
    reset      = 1'b1;
    #1;
    reset      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_im_wr", {62'd0, IM_cs, IM_wr}, 64'd0);
    chk("rst_im_addr", 64'(IM_addr), 64'd0);
    chk("rst_im_data", 64'(IM_D_in), 64'd0);
    chk("rst_hold_done_abt", {61'd0, cpu_hold, done, aborted}, 64'd0);
    chk("rst_ww", 64'(words_written), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Directed two-word load
    stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load("t1", 32'h0000_0100, 2, 0);
    chk("t1_checksum_const", 64'(checksum), 64'h8888_8888);

    // Same load with 3-cycle gaps between bytes
    run_load("t1gap", 32'h0000_0200, 2, 3);

    // Unaligned base: low bits forced to zero
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("t2", 32'h0000_0103, 1, 0);
    chk("t2_data_const", 64'(wr_data_q.size() > 0 ? wr_data_q[0] : 32'h0), 64'hAABB_CCDD);

    // Zero-length load
    stim.delete();
    run_load("t3", 32'h0000_0400, 0, 0);
    chk("t3_hold_cycles", 64'(hold_cnt), 64'd1);

    // Address wrap
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load("t4", 32'hFFFF_FFFC, 2, 0);
    chk("t4_wrap_addr", 64'(wr_addr_q.size() > 1 ? wr_addr_q[1] : 32'hDEAD_BEEF), 64'd0);

    // Abort after two bytes of the second word
    fill_random(12);
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt   = 0;
    base_addr  = 32'h0000_0800;
    word_count = 16'd3;
    start      = 1'b1;
    step();
    start      = 1'b0;
    feed(6, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_hold", {63'd0, cpu_hold}, 64'd0);
    chk("t5_aborted", {63'd0, aborted}, 64'd1);
    chk("t5_ww", 64'(words_written), 64'd1);
    chk("t5_checksum", 64'(checksum), 64'(exp_word(0)));
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    repeat (8) step();
    in_valid = 1'b0;
    chk("t5_no_more_writes", 64'(wr_addr_q.size()), 64'd1);
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    // start together with abort in IDLE: ignored, aborted unchanged
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("t5_start_abort_idle", {62'd0, cpu_hold, aborted}, 64'd1);
    // next accepted start clears aborted
    fill_random(4);
    run_load("t5b", 32'h0000_0900, 1, 0);

    // Asynchronous reset in the middle of a write cycle
    fill_random(8);
    base_addr  = 32'h0000_0A00;
    word_count = 16'd2;
    start      = 1'b1;
    step();
    start      = 1'b0;
    feed(4, 0);
    chk("t6_in_write", {62'd0, IM_cs, IM_wr}, 64'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_strobe", {62'd0, IM_cs, IM_wr}, 64'd0);
    chk("t6_rst_hold", {63'd0, cpu_hold}, 64'd0);
    chk("t6_rst_ww", 64'(words_written), 64'd0);
    chk("t6_rst_checksum", 64'(checksum), 64'd0);
    chk("t6_rst_addr_data", {IM_addr, IM_D_in}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Randomized loads with random byte gaps
    for (int n = 0; n < 6; n++) begin
      int c;
      c = int'($urandom_range(1, 4));
      fill_random(4 * c);
      run_load($sformatf("rnd%0d", n), $urandom, c, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
